// File: rtl/cache_meta_array.sv
// 2-way set-associative cache metadata (valid/dirty/tag per way, LRU per set) with
// combinational lookup/victim select, registered fill/touch updates and a flush walker.
module cache_meta_array #(
    parameter int BLKIDX_BIT = 4,
    parameter int TAG_BIT    = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BLKIDX_BIT-1:0] lk_blkidx,
    input  logic [TAG_BIT-1:0]    lk_tag,
    output logic                  lk_hit,
    output logic                  lk_hit_way,
    output logic                  lk_victim_way,
    output logic                  lk_victim_valid,
    output logic                  lk_victim_dirty,
    output logic [TAG_BIT-1:0]    lk_victim_tag,
    input  logic                  upd_en,
    input  logic                  upd_fill,
    input  logic [BLKIDX_BIT-1:0] upd_blkidx,
    input  logic                  upd_way,
    input  logic [TAG_BIT-1:0]    upd_tag,
    input  logic                  upd_dirty,
    input  logic                  flush_req,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [BLKIDX_BIT-1:0] wb_blkidx,
    output logic                  wb_way,
    output logic [TAG_BIT-1:0]    wb_tag
);
    localparam int SETS = 1 << BLKIDX_BIT;
    localparam int PW   = BLKIDX_BIT + 1;

    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

    logic               valid_q [2][SETS];
    logic               dirty_q [2][SETS];
    logic [TAG_BIT-1:0] tag_q   [2][SETS];
    logic               lru_q   [SETS];

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  clr;
    logic [BLKIDX_BIT-1:0] ptr_set;
    logic                  ptr_way;
    logic                  ptr_last;

    assign ptr_set  = ptr_q[PW-1:1];
    assign ptr_way  = ptr_q[0];
    assign ptr_last = &ptr_q;

    // Lookup: way 0 wins when both ways hold the same tag.
    logic hit0, hit1, v0, v1;
    assign v0   = valid_q[0][lk_blkidx];
    assign v1   = valid_q[1][lk_blkidx];
    assign hit0 = v0 && (tag_q[0][lk_blkidx] == lk_tag);
    assign hit1 = v1 && (tag_q[1][lk_blkidx] == lk_tag);

    assign lk_hit          = (hit0 || hit1) && !busy;
    assign lk_hit_way      = !hit0 && hit1;
    assign lk_victim_way   = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[lk_blkidx]);
    assign lk_victim_valid = valid_q[lk_victim_way][lk_blkidx];
    assign lk_victim_dirty = dirty_q[lk_victim_way][lk_blkidx];
    assign lk_victim_tag   = tag_q[lk_victim_way][lk_blkidx];

    assign busy      = (state_q == SCAN) || (state_q == WB);
    assign wb_blkidx = wb_valid ? ptr_set : '0;
    assign wb_way    = wb_valid ? ptr_way : 1'b0;
    assign wb_tag    = wb_valid ? tag_q[ptr_way][ptr_set] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr        = 1'b0;
        flush_done = 1'b0;
        wb_valid   = 1'b0;
        case (state_q)
            IDLE: if (flush_req) state_d = SCAN;
            SCAN: begin
                if (valid_q[ptr_way][ptr_set] && dirty_q[ptr_way][ptr_set]) begin
                    state_d = WB;
                end else begin
                    clr     = 1'b1;
                    ptr_d   = ptr_q + PW'(1);
                    state_d = ptr_last ? DONE : SCAN;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    clr     = 1'b1;
                    ptr_d   = ptr_q + PW'(1);
                    state_d = ptr_last ? DONE : SCAN;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush clears only happen while busy, so they never collide with an update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                end
            end
        end else begin
            if (clr) begin
                valid_q[ptr_way][ptr_set] <= 1'b0;
                dirty_q[ptr_way][ptr_set] <= 1'b0;
                lru_q[ptr_set]            <= 1'b0;
            end
            if (upd_en && !busy) begin
                lru_q[upd_blkidx] <= ~upd_way;
                if (upd_fill) begin
                    valid_q[upd_way][upd_blkidx] <= 1'b1;
                    tag_q[upd_way][upd_blkidx]   <= upd_tag;
                    dirty_q[upd_way][upd_blkidx] <= upd_dirty;
                end else begin
                    dirty_q[upd_way][upd_blkidx] <= dirty_q[upd_way][upd_blkidx] | upd_dirty;
                end
            end
        end
    end
endmodule
